// File: rtl/lcd_ctrl.sv
// lcd_ctrl: sequencer in front of the 4-bit character-LCD nibble sender.
// Runs the power-on nibble initialisation directly on the pins, then pushes the
// configuration bytes through the sender and finally serves a valid/ready
// write port for user commands and characters.
// Optional feature macro: LCD_CTRL_AUTOWRAP_EN (automatic line wrap after 16 characters).
module lcd_ctrl #(
    parameter int T_PWR   = 750000,
    parameter int T_4MS   = 205000,
    parameter int T_100US = 5000,
    parameter int T_40US  = 2000,
    parameter int T_CLR   = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    output logic       wr_ready,
    output logic       init_done,
    output logic       send_init,
    output logic [7:0] send_data,
    input  logic       send_done,
    input  logic       send_lcd_e,
    input  logic [7:0] send_lcd_db,
    output logic       lcd_e,
    output logic [7:0] lcd_db,
    output logic       lcd_rs,
    output logic       lcd_rw
);

    typedef enum logic [3:0] {
        S_PWR_WAIT   = 4'd0,
        S_INIT_SETUP = 4'd1,
        S_INIT_HOLD  = 4'd2,
        S_INIT_GAP   = 4'd3,
        S_CFG_SEND   = 4'd4,
        S_CFG_WAIT   = 4'd5,
        S_CFG_CLR    = 4'd6,
        S_READY      = 4'd7,
        S_USR_SEND   = 4'd8,
        S_USR_WAIT   = 4'd9,
        S_USR_CLR    = 4'd10,
        S_WRAP_SEND  = 4'd11,
        S_WRAP_WAIT  = 4'd12
    } state_t;

    // Terminal timer values: a wait of N cycles ends when the timer reads N-1.
    localparam logic [19:0] C_PWR_LAST   = 20'(T_PWR - 1);
    localparam logic [19:0] C_4MS_LAST   = 20'(T_4MS - 1);
    localparam logic [19:0] C_100US_LAST = 20'(T_100US - 1);
    localparam logic [19:0] C_40US_LAST  = 20'(T_40US - 1);
    localparam logic [19:0] C_CLR_LAST   = 20'(T_CLR - 1);
    localparam logic [19:0] C_SETUP_LAST = 20'd1;
    localparam logic [19:0] C_HOLD_LAST  = 20'd11;

    state_t      r_state;
    logic [19:0] r_timer;
    logic [1:0]  r_step;       // init nibble index, then configuration byte index
    logic        r_rs;         // latched register select of the user write
    logic        r_wr_ready;
    logic        r_init_done;
    logic        r_send_init;
    logic [7:0]  r_send_data;  // doubles as the latched user byte
    logic        r_pin_own;    // 1: controller drives the pins, 0: sender pass-through
    logic        r_pin_e;
    logic [7:0]  r_pin_db;
    logic        r_lcd_rs;
`ifdef LCD_CTRL_AUTOWRAP_EN
    logic        r_line;
    logic [4:0]  r_col;
`endif

    // Nibble placed on the upper data pins for each init step.
    function automatic logic [3:0] init_nib(input logic [1:0] step);
        case (step)
            2'd3:    init_nib = 4'h2;
            default: init_nib = 4'h3;
        endcase
    endfunction

    // Gap length following each init nibble.
    function automatic logic [19:0] gap_last(input logic [1:0] step);
        case (step)
            2'd0:    gap_last = C_4MS_LAST;
            2'd1:    gap_last = C_100US_LAST;
            default: gap_last = C_40US_LAST;
        endcase
    endfunction

    // Configuration bytes: 4-bit 2-line mode, entry mode, display on, clear.
    function automatic logic [7:0] cfg_byte(input logic [1:0] k);
        case (k)
            2'd0:    cfg_byte = 8'h28;
            2'd1:    cfg_byte = 8'h06;
            2'd2:    cfg_byte = 8'h0C;
            default: cfg_byte = 8'h01;
        endcase
    endfunction

    // Main sequencer: state, shared timer and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_PWR_WAIT;
            r_timer     <= 20'd0;
            r_step      <= 2'd0;
            r_rs        <= 1'b0;
            r_wr_ready  <= 1'b0;
            r_init_done <= 1'b0;
            r_send_init <= 1'b0;
            r_send_data <= 8'h00;
            r_pin_own   <= 1'b1;
            r_pin_e     <= 1'b0;
            r_pin_db    <= 8'h00;
            r_lcd_rs    <= 1'b0;
`ifdef LCD_CTRL_AUTOWRAP_EN
            r_line      <= 1'b0;
            r_col       <= 5'd0;
`endif
        end else begin
            r_timer     <= r_timer + 20'd1;
            r_send_init <= 1'b0;
            case (r_state)
                S_PWR_WAIT: begin
                    if (r_timer == C_PWR_LAST) begin
                        r_state  <= S_INIT_SETUP;
                        r_timer  <= 20'd0;
                        r_pin_db <= {init_nib(r_step), 4'hF};
                    end
                end
                S_INIT_SETUP: begin
                    if (r_timer == C_SETUP_LAST) begin
                        r_state <= S_INIT_HOLD;
                        r_timer <= 20'd0;
                        r_pin_e <= 1'b1;
                    end
                end
                S_INIT_HOLD: begin
                    if (r_timer == C_HOLD_LAST) begin
                        r_state  <= S_INIT_GAP;
                        r_timer  <= 20'd0;
                        r_pin_e  <= 1'b0;
                        r_pin_db <= 8'h00;
                    end
                end
                S_INIT_GAP: begin
                    if (r_timer == gap_last(r_step)) begin
                        r_timer <= 20'd0;
                        if (r_step == 2'd3) begin
                            // Hand the pins over to the sender for the configuration bytes.
                            r_state     <= S_CFG_SEND;
                            r_step      <= 2'd0;
                            r_pin_own   <= 1'b0;
                            r_send_init <= 1'b1;
                            r_send_data <= cfg_byte(2'd0);
                        end else begin
                            r_state  <= S_INIT_SETUP;
                            r_step   <= r_step + 2'd1;
                            r_pin_db <= {init_nib(r_step + 2'd1), 4'hF};
                        end
                    end
                end
                S_CFG_SEND: begin
                    r_state <= S_CFG_WAIT;
                    r_timer <= 20'd0;
                end
                S_CFG_WAIT: begin
                    if (send_done) begin
                        r_timer <= 20'd0;
                        if (r_step == 2'd3) begin
                            r_state <= S_CFG_CLR;
                        end else begin
                            r_state     <= S_CFG_SEND;
                            r_step      <= r_step + 2'd1;
                            r_send_init <= 1'b1;
                            r_send_data <= cfg_byte(r_step + 2'd1);
                        end
                    end
                end
                S_CFG_CLR: begin
                    if (r_timer == C_CLR_LAST) begin
                        r_state     <= S_READY;
                        r_timer     <= 20'd0;
                        r_init_done <= 1'b1;
                        r_wr_ready  <= 1'b1;
                    end
                end
                S_READY: begin
                    if (wr_valid && r_wr_ready) begin
                        r_state     <= S_USR_SEND;
                        r_timer     <= 20'd0;
                        r_wr_ready  <= 1'b0;
                        r_rs        <= wr_rs;
                        r_lcd_rs    <= wr_rs;
                        r_send_data <= wr_data;
                        r_send_init <= 1'b1;
`ifdef LCD_CTRL_AUTOWRAP_EN
                        if (!wr_rs) begin
                            r_col <= 5'd0;
                        end
`endif
                    end
                end
                S_USR_SEND: begin
                    r_state <= S_USR_WAIT;
                    r_timer <= 20'd0;
                end
                S_USR_WAIT: begin
                    if (send_done) begin
                        r_timer <= 20'd0;
                        if (!r_rs && ((r_send_data == 8'h01) || (r_send_data == 8'h02))) begin
                            // Clear and home need extra settling time on the LCD.
                            r_state <= S_USR_CLR;
`ifdef LCD_CTRL_AUTOWRAP_EN
                        end else if (r_rs && (r_col == 5'd15)) begin
                            // This character filled the line: move the cursor to the other line.
                            r_state     <= S_WRAP_SEND;
                            r_lcd_rs    <= 1'b0;
                            r_send_init <= 1'b1;
                            r_send_data <= r_line ? 8'h80 : 8'hC0;
`endif
                        end else begin
                            r_state    <= S_READY;
                            r_wr_ready <= 1'b1;
                            r_lcd_rs   <= 1'b0;
`ifdef LCD_CTRL_AUTOWRAP_EN
                            if (r_rs) begin
                                r_col <= r_col + 5'd1;
                            end
`endif
                        end
                    end
                end
                S_USR_CLR: begin
                    if (r_timer == C_CLR_LAST) begin
                        r_state    <= S_READY;
                        r_timer    <= 20'd0;
                        r_wr_ready <= 1'b1;
                        r_lcd_rs   <= 1'b0;
                    end
                end
`ifdef LCD_CTRL_AUTOWRAP_EN
                S_WRAP_SEND: begin
                    r_state <= S_WRAP_WAIT;
                    r_timer <= 20'd0;
                end
                S_WRAP_WAIT: begin
                    if (send_done) begin
                        r_state    <= S_READY;
                        r_timer    <= 20'd0;
                        r_wr_ready <= 1'b1;
                        r_line     <= ~r_line;
                        r_col      <= 5'd0;
                    end
                end
`endif
                default: begin
                    r_state    <= S_PWR_WAIT;
                    r_timer    <= 20'd0;
                    r_step     <= 2'd0;
                    r_wr_ready <= 1'b0;
                    r_pin_own  <= 1'b1;
                    r_pin_e    <= 1'b0;
                    r_pin_db   <= 8'h00;
                    r_lcd_rs   <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ready  = r_wr_ready;
    assign init_done = r_init_done;
    assign send_init = r_send_init;
    assign send_data = r_send_data;
    assign lcd_e     = r_pin_own ? r_pin_e : send_lcd_e;
    assign lcd_db    = r_pin_own ? r_pin_db : send_lcd_db;
    assign lcd_rs    = r_lcd_rs;
    assign lcd_rw    = 1'b0;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl with shortened waits (20/10/5/3/7) and a
// behavioural nibble-sender model. Sent bytes are scoreboarded against a queue
// of expected {rs,data} values pushed when stimulus is applied.
module tb_lcd_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready, init_done, send_init, lcd_e, lcd_rs, lcd_rw;
    logic [7:0] send_data, lcd_db;
    logic       send_done, send_lcd_e;
    logic [7:0] send_lcd_db;

    int n_vec = 0;
    int n_err = 0;
    int rd = 0;
    logic [8:0] exp_q[$];

    // sender model state
    logic       m_busy;
    int         m_cnt;
    logic [7:0] m_byte;

    // monitor state (written only by the monitor)
    logic [8:0] obs_arr [0:127];
    int obs_n = 0;
    int busy_err = 0;
    int rs_hi_cnt = 0;
    int rs_lo_cnt = 0;
    int e_mis_cnt = 0;
    int n_done = 0;

    lcd_ctrl #(.T_PWR(20), .T_4MS(10), .T_100US(5), .T_40US(3), .T_CLR(7)) dut (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_rs(wr_rs), .wr_data(wr_data),
        .wr_ready(wr_ready), .init_done(init_done), .send_init(send_init), .send_data(send_data),
        .send_done(send_done), .send_lcd_e(send_lcd_e), .send_lcd_db(send_lcd_db),
        .lcd_e(lcd_e), .lcd_db(lcd_db), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw)
    );

    always #5 clk = ~clk;

    // Behavioural sender: 8 busy cycles, enable pulse in the middle, one-cycle done.
    always @(posedge clk) begin
        if (!reset) begin
            m_busy <= 1'b0; m_cnt <= 0; m_byte <= 8'h00;
            send_done <= 1'b0; send_lcd_e <= 1'b0; send_lcd_db <= 8'h00;
        end else begin
            send_done <= 1'b0;
            if (m_busy) begin
                m_cnt       <= m_cnt + 1;
                send_lcd_e  <= (m_cnt >= 1) && (m_cnt <= 4);
                send_lcd_db <= m_byte;
                if (m_cnt == 7) begin
                    m_busy <= 1'b0; send_done <= 1'b1; send_lcd_e <= 1'b0; send_lcd_db <= 8'h00;
                end
            end else if (send_init === 1'b1) begin
                m_busy <= 1'b1; m_cnt <= 0; m_byte <= send_data;
            end
        end
    end

    // Monitor on the falling edge: records sends, rs during transfers, pin pass-through.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (send_init === 1'b1) begin
                if (m_busy) busy_err <= busy_err + 1;
                if (obs_n < 128) obs_arr[obs_n] <= {lcd_rs, send_data};
                obs_n <= obs_n + 1;
            end
            if (m_busy || send_init === 1'b1 || send_done === 1'b1) begin
                if (lcd_rs === 1'b1) rs_hi_cnt <= rs_hi_cnt + 1;
                else rs_lo_cnt <= rs_lo_cnt + 1;
            end
            if (init_done === 1'b1 && (lcd_e !== send_lcd_e || lcd_db !== send_lcd_db))
                e_mis_cnt <= e_mis_cnt + 1;
            if (send_done === 1'b1) n_done <= n_done + 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One user write: wait for ready, pulse valid, wait for done, measure ready gap.
    task automatic do_write(input logic rs, input logic [7:0] data, input bit has_follow,
                            input logic [8:0] follow, output bit acc_ok, output bit drop_ok,
                            output int ready_gap);
        int w;
        logic [8:0] e;
        acc_ok = 1'b0; drop_ok = 1'b0; ready_gap = -1;
        w = 0;
        while (wr_ready !== 1'b1 && w < 300) begin @(posedge clk); #1; w++; end
        if (wr_ready !== 1'b1) return;
        exp_q.push_back({rs, data});
        if (has_follow) exp_q.push_back(follow);
        wr_valid = 1'b1; wr_rs = rs; wr_data = data;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        acc_ok = 1'b1;
        drop_ok = (wr_ready === 1'b0);
        w = 0;
        while (send_done !== 1'b1 && w < 300) begin @(posedge clk); #1; w++; end
        if (send_done !== 1'b1) return;
        ready_gap = 0;
        do begin
            @(posedge clk); #1;
            if (wr_ready !== 1'b1) ready_gap++;
        end while (wr_ready !== 1'b1 && ready_gap < 400);
        while (rd < obs_n) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++; $display("FAIL send_seq: unexpected send %h, expected none", obs_arr[rd]);
            end else begin
                e = exp_q.pop_front();
                if (obs_arr[rd] !== e) begin
                    n_err++; $display("FAIL send_seq: got {rs,data}=%h, expected %h", obs_arr[rd], e);
                end
            end
            rd++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; wr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({wr_ready, init_done, send_init, send_data, lcd_e, lcd_db, lcd_rs, lcd_rw} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b done=%b si=%b sd=%h e=%b db=%h rs=%b rw=%b, expected all 0",
                     wr_ready, init_done, send_init, send_data, lcd_e, lcd_db, lcd_rs, lcd_rw);
        end
    endtask

    task automatic test_init();
        int nib_q[$];
        int gap_q[$];
        int phase, setup_n, hold_n, gap_n, pulses, ev;
        bit done;
        nib_q = '{3, 3, 3, 2};
        gap_q = '{10, 5, 3, 3};
        exp_q.push_back({1'b0, 8'h28});
        exp_q.push_back({1'b0, 8'h06});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        phase = 0; setup_n = 0; hold_n = 0; gap_n = 0; pulses = 0; done = 1'b0;
        reset = 1'b1;
        for (int c = 0; c < 400 && !done; c++) begin
            @(posedge clk); #1;
            if (lcd_e === 1'b1) begin
                if (phase != 2) begin
                    phase = 2; hold_n = 0;
                    ev = (nib_q.size() > 0) ? nib_q.pop_front() : -1;
                    n_vec++;
                    if (lcd_db !== {ev[3:0], 4'hF} || ev < 0) begin
                        n_err++; $display("FAIL init_nibble: got lcd_db=%h, expected nibble %0d with F", lcd_db, ev);
                    end
                    n_vec++;
                    if (setup_n != 2) begin
                        n_err++; $display("FAIL init_setup_len: got %0d, expected 2", setup_n);
                    end
                end
                hold_n++;
            end else if (lcd_db !== 8'h00) begin
                if (phase != 1) begin
                    if (phase == 3) begin
                        ev = (gap_q.size() > 0) ? gap_q.pop_front() : -1;
                        n_vec++;
                        if (gap_n != ev) begin
                            n_err++; $display("FAIL init_gap_len: got %0d, expected %0d", gap_n, ev);
                        end
                    end
                    phase = 1; setup_n = 0;
                end
                setup_n++;
            end else begin
                if (phase == 2) begin
                    n_vec++;
                    if (hold_n != 12) begin
                        n_err++; $display("FAIL init_hold_len: got %0d, expected 12", hold_n);
                    end
                    pulses++; phase = 3; gap_n = 0;
                end
                if (send_init === 1'b1) begin
                    ev = (gap_q.size() > 0) ? gap_q.pop_front() : -1;
                    n_vec++;
                    if (gap_n != ev) begin
                        n_err++; $display("FAIL init_last_gap: got %0d, expected %0d", gap_n, ev);
                    end
                    done = 1'b1;
                end else if (phase == 3) begin
                    gap_n++;
                end
            end
        end
        n_vec++;
        if (pulses != 4 || !done) begin
            n_err++; $display("FAIL init_pulses: got %0d pulses (cfg start=%b), expected 4 and 1", pulses, done);
        end
    endtask

    task automatic test_cfg();
        int dn, w, early, low;
        logic [8:0] e;
        dn = 0; w = 0; early = 0;
        while (dn < 4 && w < 1000) begin
            @(posedge clk); #1; w++;
            if (wr_ready !== 1'b0 || init_done !== 1'b0) early++;
            if (send_done === 1'b1) dn++;
        end
        n_vec++;
        if (dn != 4) begin n_err++; $display("FAIL cfg_done_count: got %0d, expected 4", dn); end
        n_vec++;
        if (early != 0) begin n_err++; $display("FAIL cfg_ready_early: got %0d cycles, expected 0", early); end
        low = 0;
        while (init_done !== 1'b1 && low < 100) begin
            @(posedge clk); #1;
            if (init_done !== 1'b1) low++;
        end
        n_vec++;
        if (low != 7) begin n_err++; $display("FAIL cfg_clr_wait: got %0d low cycles, expected 7", low); end
        n_vec++;
        if (wr_ready !== 1'b1) begin n_err++; $display("FAIL cfg_ready: got %b, expected 1", wr_ready); end
        while (rd < obs_n) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++; $display("FAIL cfg_seq: unexpected send %h, expected none", obs_arr[rd]);
            end else begin
                e = exp_q.pop_front();
                if (obs_arr[rd] !== e) begin
                    n_err++; $display("FAIL cfg_seq: got {rs,data}=%h, expected %h", obs_arr[rd], e);
                end
            end
            rd++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL cfg_missing: got %0d unsent, expected 0", exp_q.size()); end
    endtask

    task automatic test_char();
        bit acc, drop;
        int gap, h0, l0, m0;
        h0 = rs_hi_cnt; l0 = rs_lo_cnt; m0 = e_mis_cnt;
        do_write(1'b1, 8'h41, 1'b0, 9'h000, acc, drop, gap);
        n_vec++;
        if (!acc || !drop) begin n_err++; $display("FAIL char_accept: got acc=%b drop=%b, expected 1 1", acc, drop); end
        n_vec++;
        if (gap != 0) begin n_err++; $display("FAIL char_ready_gap: got %0d, expected 0", gap); end
        n_vec++;
        if (rs_lo_cnt != l0 || rs_hi_cnt <= h0) begin
            n_err++; $display("FAIL char_rs: got %0d low / %0d high cycles, expected 0 low", rs_lo_cnt - l0, rs_hi_cnt - h0);
        end
        n_vec++;
        if (e_mis_cnt != m0) begin n_err++; $display("FAIL pin_passthru: got %0d mismatches, expected 0", e_mis_cnt - m0); end
        n_vec++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL char_missing: got %0d unsent, expected 0", exp_q.size()); end
    endtask

    task automatic test_clear();
        logic [8:0] tbl_cmd [4];
        int tbl_gap [4];
        bit acc, drop;
        int gap, h0, l0;
        tbl_cmd = '{9'h001, 9'h002, 9'h003, 9'h101};
        tbl_gap = '{7, 7, 0, 0};
        for (int i = 0; i < 4; i++) begin
            h0 = rs_hi_cnt; l0 = rs_lo_cnt;
            do_write(tbl_cmd[i][8], tbl_cmd[i][7:0], 1'b0, 9'h000, acc, drop, gap);
            n_vec++;
            if (gap != tbl_gap[i] || !acc) begin
                n_err++; $display("FAIL clear_gap[%0d]: got %0d (acc=%b), expected %0d", i, gap, acc, tbl_gap[i]);
            end
            n_vec++;
            if ((tbl_cmd[i][8] ? (rs_lo_cnt - l0) : (rs_hi_cnt - h0)) != 0) begin
                n_err++; $display("FAIL clear_rs[%0d]: got %0d wrong-rs cycles, expected 0", i,
                                  tbl_cmd[i][8] ? (rs_lo_cnt - l0) : (rs_hi_cnt - h0));
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL clear_missing: got %0d unsent, expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] cur;
        logic prev_ready;
        logic [8:0] e;
        int n_acc, t_done, w;
        cur = 8'h50; n_acc = 0; t_done = -100;
        prev_ready = wr_ready;
        wr_valid = 1'b1; wr_rs = 1'b1; wr_data = cur;
        for (int c = 0; c < 300 && n_acc < 3; c++) begin
            @(posedge clk); #1;
            if (prev_ready === 1'b1) begin
                exp_q.push_back({1'b1, cur});
                if (n_acc > 0) begin
                    n_vec++;
                    if (c - t_done != 2) begin
                        n_err++; $display("FAIL b2b_latency: got %0d cycles done->accept, expected 2", c - t_done);
                    end
                end
                n_acc++; cur = cur + 8'd1; wr_data = cur;
                if (n_acc == 3) wr_valid = 1'b0;
            end
            if (send_done === 1'b1) t_done = c;
            prev_ready = wr_ready;
        end
        wr_valid = 1'b0;
        w = 0;
        while (wr_ready !== 1'b1 && w < 300) begin @(posedge clk); #1; w++; end
        n_vec++;
        if (n_acc != 3 || wr_ready !== 1'b1) begin
            n_err++; $display("FAIL b2b_accepts: got %0d (ready=%b), expected 3 and 1", n_acc, wr_ready);
        end
        while (rd < obs_n) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++; $display("FAIL b2b_seq: unexpected send %h, expected none", obs_arr[rd]);
            end else begin
                e = exp_q.pop_front();
                if (obs_arr[rd] !== e) begin
                    n_err++; $display("FAIL b2b_seq: got {rs,data}=%h, expected %h", obs_arr[rd], e);
                end
            end
            rd++;
        end
        n_vec++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_missing: got %0d unsent, expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        int w;
        w = 0;
        while (wr_ready !== 1'b1 && w < 300) begin @(posedge clk); #1; w++; end
        exp_q.push_back({1'b1, 8'h55});
        wr_valid = 1'b1; wr_rs = 1'b1; wr_data = 8'h55;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (!m_busy || rd + 1 != obs_n || obs_arr[rd] !== {1'b1, 8'h55}) begin
            n_err++; $display("FAIL mid_transfer: got busy=%b sends=%0d, expected transfer of 155 in flight", m_busy, obs_n - rd);
        end
        rd = obs_n;
        void'(exp_q.pop_front());
        reset = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if ({wr_ready, init_done, send_init, send_data, lcd_e, lcd_db, lcd_rs, lcd_rw} !== 21'd0) begin
            n_err++;
            $display("FAIL reset_mid_outputs: got rdy=%b done=%b si=%b sd=%h e=%b db=%h rs=%b, expected all 0",
                     wr_ready, init_done, send_init, send_data, lcd_e, lcd_db, lcd_rs);
        end
    endtask

    task automatic test_wrap();
        bit acc, drop, wrap;
        int gap, d0;
        logic [8:0] fol;
        do_write(1'b0, 8'h80, 1'b0, 9'h000, acc, drop, gap);
        n_vec++;
        if (gap != 0 || !acc) begin n_err++; $display("FAIL wrap_home_cmd: got gap %0d acc=%b, expected 0 1", gap, acc); end
        for (int i = 1; i <= 32; i++) begin
`ifdef LCD_CTRL_AUTOWRAP_EN
            wrap = (i % 16 == 0);
`else
            wrap = 1'b0;
`endif
            fol = (i == 16) ? {1'b0, 8'hC0} : {1'b0, 8'h80};
            d0 = n_done;
            do_write(1'b1, 8'h40 + 8'(i), wrap, fol, acc, drop, gap);
            n_vec++;
            if (!acc || n_done - d0 != (wrap ? 2 : 1)) begin
                n_err++; $display("FAIL wrap_done[%0d]: got %0d dones before ready (acc=%b), expected %0d",
                                  i, n_done - d0, acc, wrap ? 2 : 1);
            end
            if (!wrap) begin
                n_vec++;
                if (gap != 0) begin n_err++; $display("FAIL wrap_gap[%0d]: got %0d, expected 0", i, gap); end
            end
        end
        n_vec++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL wrap_missing: got %0d unsent, expected 0", exp_q.size()); end
        n_vec++;
        if (busy_err != 0) begin n_err++; $display("FAIL send_while_busy: got %0d, expected 0", busy_err); end
    endtask

    initial begin
        test_reset();
        test_init();
        test_cfg();
        test_char();
        test_clear();
        test_back_to_back();
        test_reset_mid();
        test_init();
        test_cfg();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
